// File: rtl/digit_accum_if.sv
// -----------------------------------------------------------------------------
// digit_accum_if
// Handshake bundle between a digit source / result consumer and digit_accum.
//   digit_in     [DIGIT_W]  digit value, MS digit first
//   digit_last   [1]        digit closes the word early
//   digit_valid  [1]        digit_in / digit_last valid
//   digit_ready  [1]        accumulator accepts a digit this cycle
//   result       [OUT_W]    packed word, stable while result_valid
//   result_valid [1]        result available
//   result_ready [1]        consumer takes the result
// master: digit source + result consumer.  slave: the accumulator.
// -----------------------------------------------------------------------------
interface digit_accum_if #(
  parameter int DIGIT_W = 4,
  parameter int OUT_W   = 16
) ();
  logic [DIGIT_W-1:0] digit_in;
  logic               digit_last;
  logic               digit_valid;
  logic               digit_ready;
  logic [OUT_W-1:0]   result;
  logic               result_valid;
  logic               result_ready;

  modport master (
    output digit_in, digit_last, digit_valid, result_ready,
    input  digit_ready, result, result_valid
  );

  modport slave (
    input  digit_in, digit_last, digit_valid, result_ready,
    output digit_ready, result, result_valid
  );
endinterface

// File: rtl/digit_accum.sv
// -----------------------------------------------------------------------------
// digit_accum
// Serial digit accumulator: packs a stream of digits (MS digit first) into one
// binary word. Hex mode shifts by DIGIT_W and adds; decimal mode multiplies by
// ten (shift-and-add, no multiplier) and adds.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a new word (clears acc/count/flags, latches mode)
//   mode       0 = hex, 1 = decimal; sampled only with start
//   bus        digit and result handshakes (digit_accum_if.slave)
//   overflow   sticky: some step exceeded OUT_W bits
//   digit_err  sticky: decimal word received a digit above 9
//   count      digits accepted in the current word
// -----------------------------------------------------------------------------
module digit_accum #(
  parameter int DIGIT_W    = 4,
  parameter int NUM_DIGITS = 4,
  parameter int OUT_W      = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            mode,
  digit_accum_if.slave                    bus,
  output logic                            overflow,
  output logic                            digit_err,
  output logic [$clog2(NUM_DIGITS+1)-1:0] count
);

  localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
  // Headroom wide enough for acc*10 + digit or (acc << DIGIT_W) + digit.
  localparam int WIDE_W = OUT_W + DIGIT_W + 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t             state_r, state_s;
  logic [OUT_W-1:0]   acc_r, acc_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               ovf_r, ovf_s;
  logic               err_r, err_s;
  logic               mode_r, mode_s;
  logic               rvalid_r;
  logic               accept_s;
  logic               last_s;
  logic [WIDE_W-1:0]  step_s;

  // One accumulation step at full width; bits above OUT_W signal overflow.
  function automatic logic [WIDE_W-1:0] step(
    input logic [OUT_W-1:0]   acc,
    input logic [DIGIT_W-1:0] digit,
    input logic               dec
  );
    logic [WIDE_W-1:0] a;
    logic [WIDE_W-1:0] d;
    a = WIDE_W'(acc);
    d = WIDE_W'(digit);
    if (dec) begin
      step = (a << 3) + (a << 1) + d;
    end else begin
      step = (a << DIGIT_W) + d;
    end
  endfunction

  // Decimal digit range check.
  function automatic logic is_bad_dec(input logic [DIGIT_W-1:0] digit);
    is_bad_dec = (digit > DIGIT_W'(4'd9));
  endfunction

  // A digit offered in the start cycle is refused so the fresh word starts clean.
  assign bus.digit_ready = (state_r == ACCUM) & ~start;

  // Next-state and datapath update; start overrides every state.
  always_comb begin
    state_s  = state_r;
    acc_s    = acc_r;
    cnt_s    = cnt_r;
    ovf_s    = ovf_r;
    err_s    = err_r;
    mode_s   = mode_r;
    accept_s = bus.digit_valid & bus.digit_ready;
    last_s   = bus.digit_last | (cnt_r == LAST_CNT);
    step_s   = step(acc_r, bus.digit_in, mode_r);
    if (start) begin
      state_s = ACCUM;
      acc_s   = {OUT_W{1'b0}};
      cnt_s   = {CNT_W{1'b0}};
      ovf_s   = 1'b0;
      err_s   = 1'b0;
      mode_s  = mode;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        ACCUM: begin
          if (accept_s) begin
            acc_s = step_s[OUT_W-1:0];
            cnt_s = cnt_r + CNT_W'(1);
            ovf_s = ovf_r | (|step_s[WIDE_W-1:OUT_W]);
            err_s = err_r | (mode_r & is_bad_dec(bus.digit_in));
            if (last_s) begin
              state_s = DONE;
            end else begin
              state_s = ACCUM;
            end
          end else begin
            state_s = ACCUM;
          end
        end
        DONE: begin
          if (bus.result_ready) begin
            state_s = IDLE;
          end else begin
            state_s = DONE;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; result_valid is registered alongside DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      acc_r    <= {OUT_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      ovf_r    <= 1'b0;
      err_r    <= 1'b0;
      mode_r   <= 1'b0;
      rvalid_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      acc_r    <= acc_s;
      cnt_r    <= cnt_s;
      ovf_r    <= ovf_s;
      err_r    <= err_s;
      mode_r   <= mode_s;
      rvalid_r <= (state_s == DONE);
    end
  end

  assign bus.result       = acc_r;
  assign bus.result_valid = rvalid_r;
  assign overflow         = ovf_r;
  assign digit_err        = err_r;
  assign count            = cnt_r;

endmodule

// File: tb/tb_digit_accum.sv
// -----------------------------------------------------------------------------
// tb_digit_accum
// Drives a 4-digit and a 5-digit accumulator. The stimulus side computes each
// word's expected value with plain integer arithmetic and queues it; a monitor
// compares whenever a DUT presents result_valid.
// -----------------------------------------------------------------------------
module tb_digit_accum;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    logic        err;
    int          cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Per-DUT stimulus (index 0: NUM_DIGITS=4, index 1: NUM_DIGITS=5).
  logic        st_a [2];
  logic        md_a [2];
  logic        dv_a [2];
  logic        dl_a [2];
  logic        rr_a [2];
  logic [3:0]  di_a [2];
  // Per-DUT observed outputs.
  logic        rv_a  [2];
  logic        rdy_a [2];
  logic [15:0] res_a [2];
  logic        ovf_a [2];
  logic        err_a [2];
  logic [2:0]  cnt_a [2];

  logic       ovf4, err4, ovf5, err5;
  logic [2:0] cnt4, cnt5;

  digit_accum_if #(.DIGIT_W(4), .OUT_W(16)) if4 ();
  digit_accum_if #(.DIGIT_W(4), .OUT_W(16)) if5 ();

  assign if4.digit_in     = di_a[0];
  assign if4.digit_last   = dl_a[0];
  assign if4.digit_valid  = dv_a[0];
  assign if4.result_ready = rr_a[0];
  assign if5.digit_in     = di_a[1];
  assign if5.digit_last   = dl_a[1];
  assign if5.digit_valid  = dv_a[1];
  assign if5.result_ready = rr_a[1];

  assign rv_a[0]  = if4.result_valid;
  assign rdy_a[0] = if4.digit_ready;
  assign res_a[0] = if4.result;
  assign ovf_a[0] = ovf4;
  assign err_a[0] = err4;
  assign cnt_a[0] = cnt4;
  assign rv_a[1]  = if5.result_valid;
  assign rdy_a[1] = if5.digit_ready;
  assign res_a[1] = if5.result;
  assign ovf_a[1] = ovf5;
  assign err_a[1] = err5;
  assign cnt_a[1] = cnt5;

  digit_accum #(.DIGIT_W(4), .NUM_DIGITS(4), .OUT_W(16)) u4 (
    .clk(clk), .rst_n(rst_n), .start(st_a[0]), .mode(md_a[0]), .bus(if4),
    .overflow(ovf4), .digit_err(err4), .count(cnt4)
  );

  digit_accum #(.DIGIT_W(4), .NUM_DIGITS(5), .OUT_W(16)) u5 (
    .clk(clk), .rst_n(rst_n), .start(st_a[1]), .mode(md_a[1]), .bus(if5),
    .overflow(ovf5), .digit_err(err5), .count(cnt5)
  );

  exp_t q [2][$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   prev_rv [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each presented result against the oldest queued word.
  always @(negedge clk) begin
    for (int w = 0; w < 2; w++) begin
      if (rv_a[w] === 1'b1) begin
        if (q[w].size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_result dut%0d: result %0h with nothing expected", w, res_a[w]);
        end else begin
          chk($sformatf("result dut%0d", w), 32'(res_a[w]), 32'(q[w][0].res));
          if (!prev_rv[w]) begin
            chk($sformatf("overflow dut%0d", w), 32'(ovf_a[w]), 32'(q[w][0].ovf));
            chk($sformatf("digit_err dut%0d", w), 32'(err_a[w]), 32'(q[w][0].err));
            chk($sformatf("count dut%0d", w), 32'(cnt_a[w]), 32'(q[w][0].cnt));
          end
        end
      end else if (prev_rv[w] && q[w].size() > 0) begin
        void'(q[w].pop_front());
      end
      prev_rv[w] = (rv_a[w] === 1'b1);
    end
  end

  // Send one word. dw holds the digits as nibbles, MS digit first.
  // complete=1: the word ends (early via last, or at NUM_DIGITS) and is queued.
  task automatic send_word(input int w, input logic md, input logic [31:0] dw,
                           input int n, input logic early, input logic complete);
    exp_t       e;
    int         v;
    logic [3:0] d;
    e = '{res: 16'h0, ovf: 1'b0, err: 1'b0, cnt: 0};
    v = 0;
    @(negedge clk);
    st_a[w] = 1'b1;
    md_a[w] = md;
    dv_a[w] = 1'b1;
    di_a[w] = 4'($urandom);
    dl_a[w] = 1'b0;
    #1 chk("ready_low_in_start", 32'(rdy_a[w]), 32'h0);
    @(negedge clk);
    st_a[w] = 1'b0;
    chk("start_digit_ignored", 32'(cnt_a[w]), 32'h0);
    for (int i = 0; i < n; i++) begin
      d = dw[4*(n-1-i) +: 4];
      di_a[w] = d;
      dv_a[w] = 1'b1;
      dl_a[w] = early && (i == n - 1);
      v = md ? (v * 10 + int'(d)) : (v * 16 + int'(d));
      if (v > 65535) e.ovf = 1'b1;
      v = v % 65536;
      if (md && d > 4'd9) e.err = 1'b1;
      if (complete && i == n - 1) begin
        e.res = 16'(v);
        e.cnt = n;
        q[w].push_back(e);
      end
      #1 chk("digit_ready_accum", 32'(rdy_a[w]), 32'h1);
      @(negedge clk);
    end
    dv_a[w] = 1'b0;
    dl_a[w] = 1'b0;
    if (complete) begin
      chk("valid_latency", 32'(rv_a[w]), 32'h1);
      chk("ready_low_in_done", 32'(rdy_a[w]), 32'h0);
      if (rr_a[w]) begin
        @(negedge clk);
        chk("valid_drop_after_take", 32'(rv_a[w]), 32'h0);
        chk("count_held_idle", 32'(cnt_a[w]), 32'(n));
      end
    end else begin
      chk("count_partial", 32'(cnt_a[w]), 32'(n));
    end
  endtask

  initial begin
    int         w, nd, n;
    logic       md, early;
    logic [31:0] dw;
    logic [3:0]  dg;

    for (int i = 0; i < 2; i++) begin
      st_a[i] = 1'b0; md_a[i] = 1'b0; dv_a[i] = 1'b0;
      dl_a[i] = 1'b0; rr_a[i] = 1'b1; di_a[i] = 4'h0;
    end
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_result", 32'(res_a[i]), 32'h0);
      chk("reset_valid", 32'(rv_a[i]), 32'h0);
      chk("reset_ready", 32'(rdy_a[i]), 32'h0);
      chk("reset_count", 32'(cnt_a[i]), 32'h0);
      chk("reset_flags", {30'h0, ovf_a[i], err_a[i]}, 32'h0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic hex, decimal, early end.
    send_word(0, 1'b0, 32'h1248, 4, 1'b0, 1'b1);
    send_word(0, 1'b1, 32'h4095, 4, 1'b0, 1'b1);
    send_word(0, 1'b1, 32'h9999, 4, 1'b0, 1'b1);
    send_word(0, 1'b0, 32'h00AB, 2, 1'b1, 1'b1);

    // Flags on the five-digit instance; the last word shows they clear.
    send_word(1, 1'b0, 32'hFFFF1, 5, 1'b0, 1'b1);
    send_word(1, 1'b1, 32'h65536, 5, 1'b0, 1'b1);
    send_word(1, 1'b1, 32'h0001C, 2, 1'b1, 1'b1);
    send_word(1, 1'b0, 32'h00012, 2, 1'b1, 1'b1);

    // Backpressure: result held, further digits refused.
    rr_a[0] = 1'b0;
    send_word(0, 1'b0, 32'h5A3C, 4, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      dv_a[0] = 1'b1;
      di_a[0] = 4'($urandom);
      #1 chk("ready_low_backpressure", 32'(rdy_a[0]), 32'h0);
      chk("valid_held", 32'(rv_a[0]), 32'h1);
      @(negedge clk);
      chk("count_held_done", 32'(cnt_a[0]), 32'h4);
    end
    dv_a[0] = 1'b0;
    // start in DONE discards the untaken result.
    st_a[0] = 1'b1;
    md_a[0] = 1'b0;
    @(negedge clk);
    st_a[0] = 1'b0;
    rr_a[0] = 1'b1;
    chk("discard_valid", 32'(rv_a[0]), 32'h0);
    chk("discard_count", 32'(cnt_a[0]), 32'h0);
    // Abort mid-word, then a full word.
    send_word(0, 1'b0, 32'h0077, 2, 1'b0, 1'b0);
    send_word(0, 1'b0, 32'h1234, 4, 1'b0, 1'b1);

    // Randomized words on both instances.
    for (int k = 0; k < 40; k++) begin
      w  = int'($urandom_range(0, 1));
      nd = (w == 0) ? 4 : 5;
      md = 1'($urandom_range(0, 1));
      n  = int'($urandom_range(1, nd));
      early = (n < nd) ? 1'b1 : 1'($urandom_range(0, 1));
      dw = 32'h0;
      for (int i = 0; i < n; i++) begin
        if (md && $urandom_range(0, 7) != 0) dg = 4'($urandom_range(0, 9));
        else dg = 4'($urandom);
        dw = (dw << 4) | 32'(dg);
      end
      send_word(w, md, dw, n, early, 1'b1);
    end

    // Asynchronous reset mid-word.
    send_word(0, 1'b1, 32'h003C, 2, 1'b0, 1'b0);
    chk("err_before_reset", 32'(err_a[0]), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_result", 32'(res_a[0]), 32'h0);
    chk("async_rst_count", 32'(cnt_a[0]), 32'h0);
    chk("async_rst_flags", {30'h0, ovf_a[0], err_a[0]}, 32'h0);
    chk("async_rst_valid_ready", {30'h0, rv_a[0], rdy_a[0]}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dv_a[0] = 1'b1;
      di_a[0] = 4'($urandom);
      #1 chk("post_reset_ready", 32'(rdy_a[0]), 32'h0);
      @(negedge clk);
      chk("post_reset_count", 32'(cnt_a[0]), 32'h0);
    end
    dv_a[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("queue_drained_dut0", 32'(q[0].size()), 32'h0);
    chk("queue_drained_dut1", 32'(q[1].size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
